// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the ME stage. Word-organised
//               on-chip array answering one load/store at a time after
//               WAIT_CYCLES wait states. Store byte-lane steering, load
//               sign/zero extension, stall while a request is outstanding.
//               Optional macro DMEM_MISALIGN_EN enables misalignment faults
//               reported on oErr.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [31:0] iAddr,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    input  logic [31:0] iWData,
    output logic [31:0] oRData,
    output logic        oAck,
    output logic        oStall,
    output logic        oErr
);

    localparam int         c_depth = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_wait  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;

    // Captured request fields, used while the request sits in WAIT
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [1:0]              r_off;
    logic [1:0]              r_size;
    logic                    r_uns;
    logic [31:0]             r_wdata;

    logic [31:0]             r_mem [0:c_depth-1];

    // Effective request: live inputs when accepting from IDLE, captured copy otherwise
    logic                    w_sel_live;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [1:0]              w_off;
    logic [1:0]              w_size;
    logic                    w_uns;
    logic [31:0]             w_wdata;

    logic                    w_enter_resp;
    logic                    w_err;
    logic                    w_commit;
    logic [3:0]              w_be;
    logic [31:0]             w_lanes;
    logic [31:0]             w_rd_word;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_load;

    assign w_sel_live = (r_state == S_IDLE);
    assign w_we       = w_sel_live ? iWe                   : r_we;
    assign w_idx      = w_sel_live ? iAddr[ADDR_WIDTH+1:2] : r_idx;
    assign w_off      = w_sel_live ? iAddr[1:0]            : r_off;
    assign w_size     = w_sel_live ? iSize                 : r_size;
    assign w_uns      = w_sel_live ? iUnsigned             : r_uns;
    assign w_wdata    = w_sel_live ? iWData                : r_wdata;

    // The transition into RESP is where stores commit and load data is registered
    assign w_enter_resp = ~iRst &
                          (((r_state == S_IDLE) & iReq & (c_wait == 4'd0)) |
                           ((r_state == S_WAIT) & (r_cnt <= 4'd1)));

`ifdef DMEM_MISALIGN_EN
    assign w_err = (w_size == 2'b11) |
                   ((w_size == 2'b01) & w_off[0]) |
                   ((w_size == 2'b10) & (w_off != 2'b00));
`else
    assign w_err = 1'b0;
`endif

    assign w_commit  = w_enter_resp & w_we & ~w_err;
    assign w_rd_word = r_mem[w_idx];
    assign oStall    = iReq & ~oAck;

    // Address bits above the array are aliased and intentionally ignored
    if (ADDR_WIDTH < 30) begin : g_unused_addr
        logic w_unused_addr;
        assign w_unused_addr = ^iAddr[31:ADDR_WIDTH+2];
    end

    // Store steering: replicate data across lanes and enable only the addressed ones
    always_comb begin
        w_be    = 4'b1111;
        w_lanes = w_wdata;
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_lanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = w_wdata;
            end
        endcase
    end

    // Load extraction: pick lane(s), right-align, extend per size and signedness
    always_comb begin
        w_byte = 8'h00;
        case (w_off)
            2'b00:   w_byte = w_rd_word[7:0];
            2'b01:   w_byte = w_rd_word[15:8];
            2'b10:   w_byte = w_rd_word[23:16];
            default: w_byte = w_rd_word[31:24];
        endcase
        w_half = w_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (w_size)
            2'b00:   w_load = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = w_rd_word;
        endcase
    end

    // Control FSM with registered response outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            oAck    <= 1'b0;
            oRData  <= 32'h0;
            oErr    <= 1'b0;
        end else begin
            oAck   <= 1'b0;
            oRData <= 32'h0;
            oErr   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iReq) begin
                        r_cnt   <= c_wait;
                        r_state <= (c_wait == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_enter_resp) begin
                oAck   <= 1'b1;
                oErr   <= w_err;
                oRData <= (w_we | w_err) ? 32'h0 : w_load;
            end
        end
    end

    // Capture request fields on acceptance; contents are don't-care otherwise
    always_ff @(posedge iClk) begin
        if ((r_state == S_IDLE) & iReq) begin
            r_we    <= iWe;
            r_idx   <= iAddr[ADDR_WIDTH+1:2];
            r_off   <= iAddr[1:0];
            r_size  <= iSize;
            r_uns   <= iUnsigned;
            r_wdata <= iWData;
        end
    end

    // Byte-enabled array write; the array is never reset
    always_ff @(posedge iClk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Two instances:
//               index 0 with WAIT_CYCLES=2, index 1 with WAIT_CYCLES=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_EN
    localparam bit c_mis = 1'b1;
`else
    localparam bit c_mis = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic        uns   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [1:0]  size  [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        stall [2];
    logic        err   [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] mb [2][16384];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut_w2 (
        .iClk(clk), .iRst(rst), .iReq(req[0]), .iWe(we[0]), .iAddr(addr[0]),
        .iSize(size[0]), .iUnsigned(uns[0]), .iWData(wdata[0]),
        .oRData(rdata[0]), .oAck(ack[0]), .oStall(stall[0]), .oErr(err[0])
    );

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_w0 (
        .iClk(clk), .iRst(rst), .iReq(req[1]), .iWe(we[1]), .iAddr(addr[1]),
        .iSize(size[1]), .iUnsigned(uns[1]), .iWData(wdata[1]),
        .oRData(rdata[1]), .oAck(ack[1]), .oStall(stall[1]), .oErr(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory, natural alignment by access size
    task automatic model(input int inst, input bit w, input logic [31:0] a,
                         input logic [1:0] s, input bit u, input logic [31:0] d,
                         output logic [31:0] er, output bit ee);
        int     n;
        int     lo;
        int     base;
        longint v;
        n  = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        lo = int'(a[13:0]);
        ee = c_mis && ((s == 2'd3) || (lo % n != 0));
        base = lo - (lo % n);
        er = 32'h0;
        if (!ee) begin
            if (w) begin
                for (int i = 0; i < n; i++) mb[inst][base+i] = d[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v + (longint'(mb[inst][base+i]) << (8*i));
                if (n < 4 && !u && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
                er = 32'(v);
            end
        end
    endtask

    task automatic do_req(input int inst, input bit w, input logic [31:0] a,
                          input logic [1:0] s, input bit u, input logic [31:0] d,
                          output logic [31:0] rd, output bit e, output int lat,
                          output int stall_cnt);
        @(posedge clk); #1;
        req[inst] = 1'b1; we[inst] = w; addr[inst] = a; size[inst] = s;
        uns[inst] = u; wdata[inst] = d;
        lat = -1; stall_cnt = 0; rd = 32'h0; e = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall[inst]) stall_cnt++;
            if (ack[inst]) begin
                lat = c; rd = rdata[inst]; e = err[inst];
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req[inst] = 1'b0;
    endtask

    task automatic txn(input string name, input int inst, input bit w, input logic [31:0] a,
                       input logic [1:0] s, input bit u, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_e);
        logic [31:0] rd;
        bit          e;
        int          lat;
        int          sc;
        int          wc;
        wc = (inst == 0) ? 2 : 0;
        do_req(inst, w, a, s, u, d, rd, e, lat, sc);
        check({name, ".latency"}, 32'(lat), 32'(wc + 1));
        check({name, ".stall_cycles"}, 32'(sc), 32'(wc + 1));
        check({name, ".rdata"}, rd, exp_rd);
        check({name, ".err"}, {31'h0, e}, {31'h0, exp_e});
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [31:0] er;
        bit          ee;
        logic [31:0] exp_b2b [3];
        int          k;
        int          acks;
        logic [31:0] v40;

        v40 = c_mis ? 32'h11111111 : 32'h12345678;
        tbl[0]  = '{1'b1, 32'h10,   2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h13,   2'd0, 1'b0, 32'hAAAAAA80, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h13,   2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[4]  = '{1'b0, 32'h13,   2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0};
        tbl[5]  = '{1'b0, 32'h10,   2'd2, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 32'h20,   2'd2, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 32'h22,   2'd1, 1'b0, 32'h55551234, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 32'h22,   2'd1, 1'b1, 32'h0,        32'h00001234, 1'b0};
        tbl[9]  = '{1'b0, 32'h20,   2'd2, 1'b0, 32'h0,        32'h1234F00D, 1'b0};
        tbl[10] = '{1'b1, 32'h22,   2'd1, 1'b0, 32'h00008001, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h22,   2'd1, 1'b0, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[12] = '{1'b0, 32'h20,   2'd0, 1'b0, 32'h0,        32'h0000000D, 1'b0};
        tbl[13] = '{1'b0, 32'h4010, 2'd2, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0};
        tbl[14] = '{1'b1, 32'h40,   2'd2, 1'b0, 32'h11111111, 32'h0,        1'b0};
        tbl[15] = '{1'b1, 32'h41,   2'd2, 1'b0, 32'h12345678, 32'h0,        c_mis};
        tbl[16] = '{1'b0, 32'h40,   2'd2, 1'b0, 32'h0,        v40,          1'b0};
        tbl[17] = '{1'b0, 32'h40,   2'd3, 1'b0, 32'h0,        c_mis ? 32'h0 : v40, c_mis};
        tbl[18] = '{1'b0, 32'h23,   2'd1, 1'b1, 32'h0,        c_mis ? 32'h0 : 32'h00008001, c_mis};
        tbl[19] = '{1'b0, 32'h11,   2'd0, 1'b1, 32'h0,        32'h000000BE, 1'b0};

        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; uns[i] = 1'b0;
            addr[i] = 32'h0; wdata[i] = 32'h0; size[i] = 2'd0;
        end

        // Reset state, and reset priority over a request
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.ack",   {31'h0, ack[0]},   32'h0);
        check("reset.rdata", rdata[0],          32'h0);
        check("reset.err",   {31'h0, err[0]},   32'h0);
        check("reset.stall_idle", {31'h0, stall[0]}, 32'h0);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; size[0] = 2'd2;
        @(negedge clk);
        check("reset.stall_follows_req", {31'h0, stall[0]}, 32'h1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack[0]) acks++;
        end
        check("reset.no_capture", 32'(acks), 32'h0);

        // Directed vectors on the WAIT_CYCLES=2 instance
        for (int i = 0; i < 20; i++) begin
            txn($sformatf("vec%0d", i), 0, tbl[i].we, tbl[i].addr, tbl[i].size,
                tbl[i].uns, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);
        end

        // Reset during the first WAIT cycle of a store discards it
        txn("rst_seq.store1", 0, 1'b1, 32'h40, 2'd2, 1'b0, 32'h11111111, 32'h0, 1'b0);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; size[0] = 2'd2; wdata[0] = 32'h55555555;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req[0] = 1'b0;
        @(negedge clk);
        check("rst_seq.ack",   {31'h0, ack[0]}, 32'h0);
        check("rst_seq.rdata", rdata[0],        32'h0);
        check("rst_seq.err",   {31'h0, err[0]}, 32'h0);
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack[0]) acks++;
        end
        check("rst_seq.no_ack", 32'(acks), 32'h0);
        txn("rst_seq.load", 0, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h11111111, 1'b0);

        // Randomized traffic against the model on both instances
        for (int inst = 0; inst < 2; inst++) begin
            for (int wd = 0; wd < 64; wd++) begin
                logic [31:0] d;
                logic [31:0] a;
                d = $urandom;
                a = 32'h400 + 32'(wd * 4);
                model(inst, 1'b1, a, 2'd2, 1'b0, d, er, ee);
                txn("init", inst, 1'b1, a, 2'd2, 1'b0, d, er, ee);
            end
            for (int n = 0; n < 60; n++) begin
                logic [31:0] a;
                logic [31:0] d;
                logic [1:0]  s;
                bit          w;
                bit          u;
                a = {18'($urandom), 14'h400 + 14'($urandom_range(0, 255))};
                d = $urandom;
                s = 2'($urandom);
                w = 1'($urandom);
                u = 1'($urandom);
                model(inst, w, a, s, u, d, er, ee);
                txn($sformatf("rand%0d_%0d", inst, n), inst, w, a, s, u, d, er, ee);
            end
        end

        // Back-to-back loads on the WAIT_CYCLES=0 instance
        for (int i = 0; i < 3; i++) begin
            model(1, 1'b0, 32'h400 + 32'(i * 4), 2'd2, 1'b0, 32'h0, exp_b2b[i], ee);
        end
        k = 0;
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b0; size[1] = 2'd2; uns[1] = 1'b0; addr[1] = 32'h400;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("b2b.ack%0d", c),   {31'h0, ack[1]},   32'(c % 2));
            check($sformatf("b2b.stall%0d", c), {31'h0, stall[1]}, 32'((c + 1) % 2));
            if (ack[1] && k < 3) begin
                check($sformatf("b2b.rdata%0d", k), rdata[1], exp_b2b[k]);
                k++;
            end
            @(posedge clk); #1;
            if (c % 2 == 1) begin
                if (k >= 3) req[1] = 1'b0;
                else addr[1] = 32'h400 + 32'(k * 4);
            end
        end
        req[1] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
